// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared GPR constants and writeback request type.
// The decode stage and the register file use the same widths, so they live here.
// The constants carry a GPR_ prefix so that modules can import this package and
// still declare their own AW/DW parameters without name clashes.
package gpr_wb_arbiter_pkg;

  localparam int GPR_AW   = 5;
  localparam int GPR_DW   = 32;
  localparam int NREG     = 2**GPR_AW;
  localparam int REG_ZERO = 0;

  // One writeback source as seen by the arbiter.
  typedef struct packed {
    logic              valid;
    logic [GPR_AW-1:0] addr;
    logic [GPR_DW-1:0] data;
  } wb_req_t;

  // Wraps an index that has gone at most one lap past n back into 0..n-1.
  // Used for both the round-robin scan and the pointer advance.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr.sv
// Combinational round-robin arbiter.
// The scan starts at ptr and walks upward with wrap-around; the first active
// request wins. The pointer register itself belongs to the instantiating block,
// so this module stays purely combinational.
module rr_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int PW = $clog2(N);

  logic found;
  int   idx;

  // Scan from ptr with wrap and grant the first requester found (one-hot plus index).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = rr_wrap(int'(ptr) + k, N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter.
// Several writeback sources (ALU, load, mul/div) share the single GPR write port.
// A round-robin grant picks one source per cycle; the winner is captured in a
// registered output stage that drives RegWr/address/WD one cycle later.
// A per-register pending scoreboard lets decode spot RAW hazards on rs/rt.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = GPR_AW,
  parameter int DW   = GPR_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic [AW-1:0]     rs,
  input  logic [AW-1:0]     rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              gpr_we,
  output logic [AW-1:0]     gpr_waddr,
  output logic [DW-1:0]     gpr_wdata,
  output logic [2**AW-1:0]  pending
);

  localparam int PW = $clog2(NREQ);
  localparam int NR = 2**AW;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr;
  logic            any_gnt;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NR-1:0]   set_mask;
  logic [NR-1:0]   clr_mask;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // There is no stall input, so a grant is also the transfer.
  assign req_ready = gnt;
  assign any_gnt   = |gnt;
  assign win_addr  = req_addr[gnt_idx*AW +: AW];
  assign win_data  = req_data[gnt_idx*DW +: DW];

  // Capture the winner into the output stage and move the pointer past it.
  // Address 0 is consumed but never written, so RegWr stays low for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      gpr_we    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else if (any_gnt) begin
      ptr       <= PW'(rr_wrap(int'(gnt_idx) + 1, NREQ));
      gpr_we    <= (win_addr != AW'(REG_ZERO));
      gpr_waddr <= win_addr;
      gpr_wdata <= win_data;
    end else begin
      gpr_we    <= 1'b0;
    end
  end

  // Build the scoreboard set/clear masks for this cycle.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_addr != AW'(REG_ZERO))) begin
      set_mask[iss_addr] = 1'b1;
    end
    if (any_gnt) begin
      clr_mask[win_addr] = 1'b1;
    end
  end

  // Update pending bits; set is applied after clear so a newer in-flight writer wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // The output-stage term covers the cycle after the grant, when the pending
  // bit is already cleared but the GPR has not been written yet.
  assign rs_busy = (rs != AW'(REG_ZERO)) &&
                   (pending[rs] || (gpr_we && (gpr_waddr == rs)));
  assign rt_busy = (rt != AW'(REG_ZERO)) &&
                   (pending[rt] || (gpr_we && (gpr_waddr == rt)));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Testbench for gpr_wb_arbiter: directed steps with a scoreboard queue of
// expected GPR writes, compared one cycle after each grant.
module tb_gpr_wb_arbiter;
  import gpr_wb_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = GPR_AW;
  localparam int DW   = GPR_DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic              rs_busy;
  logic              rt_busy;
  logic              gpr_we;
  logic [AW-1:0]     gpr_waddr;
  logic [DW-1:0]     gpr_wdata;
  logic [2**AW-1:0]  pending;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  wb_req_t       reqs[NREQ];
  int            checks = 0;
  int            passes = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  gpr_wb_arbiter #(
    .NREQ(NREQ),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .rs       (rs),
    .rt       (rt),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .gpr_we   (gpr_we),
    .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata),
    .pending  (pending)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = reqs[i].valid;
      req_addr[i*AW +: AW]   = reqs[i].addr;
      req_data[i*DW +: DW]   = reqs[i].data;
    end
  endtask

  // One clock: check the grant, push the expected GPR write, then pop and compare after the edge.
  task automatic tick(input logic [NREQ-1:0] exp_ready);
    exp_t e;
    int   w;
    apply_stimulus();
    #1;
    check_output("req_ready", 64'(req_ready), 64'(exp_ready));
    w = -1;
    for (int i = 0; i < NREQ; i++) if (exp_ready[i]) w = i;
    if (w >= 0) begin
      e.we      = (reqs[w].addr != '0);
      e.addr    = reqs[w].addr;
      e.data    = reqs[w].data;
      last_addr = reqs[w].addr;
      last_data = reqs[w].data;
    end else begin
      e.we   = 1'b0;
      e.addr = last_addr;
      e.data = last_data;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_output("gpr_we", 64'(gpr_we), 64'(e.we));
    check_output("gpr_waddr", 64'(gpr_waddr), 64'(e.addr));
    check_output("gpr_wdata", 64'(gpr_wdata), 64'(e.data));
  endtask

  // Hard bound on simulation time in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    rs        = '0;
    rt        = '0;
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < NREQ; i++) reqs[i] = '0;

    // Reset held, then released between edges with no traffic.
    #2;
    check_output("rst_gpr_we", 64'(gpr_we), 64'd0);
    check_output("rst_pending", 64'(pending), 64'd0);
    #10;
    rst = 1'b1;
    #1;
    check_output("idle_ready", 64'(req_ready), 64'd0);
    check_output("idle_gpr_we", 64'(gpr_we), 64'd0);
    check_output("idle_pending", 64'(pending), 64'd0);
    check_output("idle_rs_busy", 64'(rs_busy), 64'd0);
    check_output("idle_rt_busy", 64'(rt_busy), 64'd0);

    // Three requesters held valid: round-robin 0,1,2,0.
    reqs[0] = '{valid: 1'b1, addr: 5'd1, data: 32'hAAAA_0001};
    reqs[1] = '{valid: 1'b1, addr: 5'd2, data: 32'hBBBB_0002};
    reqs[2] = '{valid: 1'b1, addr: 5'd3, data: 32'hCCCC_0003};
    tick(3'b001);
    tick(3'b010);
    tick(3'b100);
    tick(3'b001);
    for (int i = 0; i < NREQ; i++) reqs[i].valid = 1'b0;
    tick(3'b000);

    // Issue to r5, then write it back: busy through the output-stage cycle.
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    rs        = 5'd5;
    rt        = 5'd3;
    tick(3'b000);
    check_output("pend5_set", 64'(pending[5]), 64'd1);
    check_output("rs_busy_pend", 64'(rs_busy), 64'd1);
    check_output("rt_busy_clear", 64'(rt_busy), 64'd0);
    iss_valid = 1'b0;
    reqs[0] = '{valid: 1'b1, addr: 5'd5, data: 32'h5555_5555};
    tick(3'b001);
    check_output("pend5_clr", 64'(pending[5]), 64'd0);
    check_output("rs_busy_wb", 64'(rs_busy), 64'd1);
    reqs[0].valid = 1'b0;
    tick(3'b000);
    check_output("rs_busy_done", 64'(rs_busy), 64'd0);

    // Issue and writeback of r7 in the same cycle: the new issue keeps it pending.
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    reqs[1] = '{valid: 1'b1, addr: 5'd7, data: 32'h7777_7777};
    tick(3'b010);
    check_output("pend7_set_wins", 64'(pending[7]), 64'd1);
    iss_valid = 1'b0;
    reqs[1].valid = 1'b0;
    rt = 5'd7;
    tick(3'b000);
    check_output("pend7_hold", 64'(pending[7]), 64'd1);
    check_output("rt_busy_pend7", 64'(rt_busy), 64'd1);

    // Write to r0 is granted and consumed without RegWr.
    rs = 5'd0;
    reqs[2] = '{valid: 1'b1, addr: 5'd0, data: 32'hDEAD_BEEF};
    apply_stimulus();
    #1;
    check_output("rs0_busy_pre", 64'(rs_busy), 64'd0);
    tick(3'b100);
    check_output("rs0_busy_post", 64'(rs_busy), 64'd0);
    check_output("pend0", 64'(pending[0]), 64'd0);
    reqs[2].valid = 1'b0;

    // Asynchronous reset mid-cycle with a write in flight and r9 pending.
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    rs        = 5'd9;
    reqs[1] = '{valid: 1'b1, addr: 5'd4, data: 32'h4444_4444};
    tick(3'b010);
    check_output("pend9_set", 64'(pending[9]), 64'd1);
    iss_valid = 1'b0;
    reqs[1].valid = 1'b0;
    apply_stimulus();
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_gpr_we", 64'(gpr_we), 64'd0);
    check_output("arst_pending", 64'(pending), 64'd0);
    check_output("arst_rs_busy", 64'(rs_busy), 64'd0);
    check_output("arst_rt_busy", 64'(rt_busy), 64'd0);
    sb.delete();
    last_addr = '0;
    last_data = '0;
    #2;
    rst = 1'b1;

    // After reset the pointer restarts at requester 0.
    reqs[0] = '{valid: 1'b1, addr: 5'd1, data: 32'h1111_0001};
    reqs[1] = '{valid: 1'b1, addr: 5'd2, data: 32'h2222_0002};
    reqs[2] = '{valid: 1'b1, addr: 5'd3, data: 32'h3333_0003};
    tick(3'b001);
    tick(3'b010);
    for (int i = 0; i < NREQ; i++) reqs[i].valid = 1'b0;
    tick(3'b000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
